group_mac_window: RTL and testbench

- Next-generation MAC group: GROUP_NB signed multiply-accumulate lanes fed by a valid/ready stream.
- The stream carries explicit window delimiters (first/last), so each kernel window produces one result per lane.
- Each result is arithmetically shifted, saturated to OUT_WIDTH and flagged on overflow.
- Results queue in a 2-entry output buffer with ready backpressure to the requantise/writeback stage.

---
 rtl/group_mac_window_pkg.sv | 27 ++
 rtl/group_mac_window_mac_lane_sat.sv | 53 +++++
 rtl/group_mac_window.sv | 109 ++++++++++
 tb/tb_group_mac_window.sv | 133 +++++++++++++
 4 files changed

// File: rtl/group_mac_window_pkg.sv
// group_mac_window_pkg: shared widths, saturation limits and the shift/saturate helper.
package group_mac_window_pkg;
    localparam int IMG_WIDTH_DEF = 16;
    localparam int KER_WIDTH_DEF = 16;
    localparam int ACC_WIDTH_DEF = 40;
    localparam int OUT_WIDTH_DEF = 16;
    localparam int PROD_WIDTH = IMG_WIDTH_DEF + KER_WIDTH_DEF;
    localparam int OUT_MAX = 2 ** (OUT_WIDTH_DEF - 1) - 1;
    localparam int OUT_MIN = -(2 ** (OUT_WIDTH_DEF - 1));

    typedef struct packed {
        logic ovf;
        logic signed [63:0] val;
    } sat_t;

    // Accumulators up to 64 bits are sign-extended in, the result is truncated by the caller.
    function automatic sat_t sat_shift(input logic signed [63:0] a, input int sh, input int ow);
        sat_t r;
        logic signed [63:0] s, mx, mn;
        s = a >>> sh;
        mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
        mn = ~mx;
        r.ovf = (s > mx) || (s < mn);
        r.val = (s > mx) ? mx : (s < mn) ? mn : s;
        return r;
    endfunction
endpackage

// File: rtl/group_mac_window_mac_lane_sat.sv
// mac_lane_sat: one MAC lane - registered product, window accumulator with wrap tracking, close-time saturation.
module mac_lane_sat
    import group_mac_window_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int KER_WIDTH = KER_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int SHIFT = 8,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IMG_WIDTH-1:0] i_img,
    input  logic [KER_WIDTH-1:0] i_ker,
    input  logic                 i_v2,
    input  logic                 i_first2,
    input  logic                 i_close,
    output logic [OUT_WIDTH-1:0] o_res,
    output logic                 o_ovf
);
    localparam int PW = IMG_WIDTH + KER_WIDTH;

    logic signed [PW-1:0] r_prod;
    logic signed [ACC_WIDTH-1:0] r_acc, w_pext, w_sum;
    logic r_sticky, w_wrap, w_restart;
    sat_t w_sat;

    assign w_pext = ACC_WIDTH'(r_prod);
    assign w_sum = r_acc + w_pext;
    assign w_wrap = (r_acc[ACC_WIDTH-1] == w_pext[ACC_WIDTH-1]) && (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
    // A closing window hands the accumulator to the buffer this cycle, so the next beat starts fresh.
    assign w_restart = i_first2 | i_close;
    assign w_sat = sat_shift(64'(r_acc), SHIFT, OUT_WIDTH);
    assign o_res = OUT_WIDTH'(w_sat.val);
    assign o_ovf = w_sat.ovf | r_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod <= '0;
            r_acc <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_prod <= PW'($signed(i_img)) * PW'($signed(i_ker));
            if (i_v2) begin
                r_acc <= w_restart ? w_pext : w_sum;
                r_sticky <= !w_restart && (r_sticky | w_wrap);
            end else if (i_close) begin
                r_acc <= '0;
                r_sticky <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/group_mac_window.sv
// group_mac_window: GROUP_NB windowed MAC lanes with flag pipeline, pending-window throttle and 2-entry result FIFO.
module group_mac_window
    import group_mac_window_pkg::*;
#(
    parameter int GROUP_NB = 4,
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int KER_WIDTH = KER_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int SHIFT = 8,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] img,
    input  logic [GROUP_NB*KER_WIDTH-1:0] ker,
    input  logic                          val,
    input  logic                          first,
    input  logic                          last,
    output logic                          rdy,
    output logic [GROUP_NB*OUT_WIDTH-1:0] result,
    output logic [GROUP_NB-1:0]           result_ovf,
    output logic                          result_val,
    input  logic                          result_rdy
);
    logic r_v1, r_f1, r_l1, r_v2, r_f2, r_l2, r_l3, r_rdy, r_wp, r_rp;
    logic [GROUP_NB*IMG_WIDTH-1:0] r_img;
    logic [GROUP_NB*KER_WIDTH-1:0] r_ker;
    logic [1:0] r_pend, w_pend_nxt, r_cnt;
    logic [GROUP_NB*OUT_WIDTH-1:0] r_buf_res [2];
    logic [GROUP_NB-1:0] r_buf_ovf [2];
    logic [GROUP_NB*OUT_WIDTH-1:0] w_res;
    logic [GROUP_NB-1:0] w_ovf;
    logic w_acc, w_push, w_pop;

    assign w_acc = val & r_rdy;
    assign w_push = r_l3;
    assign w_pop = result_val & result_rdy;
    assign w_pend_nxt = r_pend + 2'(w_acc & last) - 2'(w_pop);
    assign rdy = r_rdy;
    assign result_val = r_cnt != 2'd0;
    assign result = r_buf_res[r_rp];
    assign result_ovf = r_buf_ovf[r_rp];

    for (genvar g = 0; g < GROUP_NB; g++) begin : g_lane
        mac_lane_sat #(
            .IMG_WIDTH(IMG_WIDTH),
            .KER_WIDTH(KER_WIDTH),
            .ACC_WIDTH(ACC_WIDTH),
            .SHIFT(SHIFT),
            .OUT_WIDTH(OUT_WIDTH)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .i_img(r_img[g*IMG_WIDTH +: IMG_WIDTH]),
            .i_ker(r_ker[g*KER_WIDTH +: KER_WIDTH]),
            .i_v2(r_v2),
            .i_first2(r_f2),
            .i_close(r_l3),
            .o_res(w_res[g*OUT_WIDTH +: OUT_WIDTH]),
            .o_ovf(w_ovf[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_v1, r_f1, r_l1, r_v2, r_f2, r_l2, r_l3, r_rdy} <= '0;
            r_img <= '0;
            r_ker <= '0;
            r_pend <= '0;
        end else begin
            r_v1 <= w_acc;
            r_f1 <= w_acc & first;
            r_l1 <= w_acc & last;
            if (w_acc) begin
                r_img <= img;
                r_ker <= ker;
            end
            r_v2 <= r_v1;
            r_f2 <= r_f1;
            r_l2 <= r_l1;
            r_l3 <= r_l2;
            r_pend <= w_pend_nxt;
            // Registered from the next count so rdy never sees result_rdy or val combinationally.
            r_rdy <= w_pend_nxt != 2'd2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_res[0] <= '0;
            r_buf_res[1] <= '0;
            r_buf_ovf[0] <= '0;
            r_buf_ovf[1] <= '0;
            r_wp <= 1'b0;
            r_rp <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_buf_res[r_wp] <= w_res;
                r_buf_ovf[r_wp] <= w_ovf;
                r_wp <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && !w_pop && r_cnt == 2'd2));
endmodule

// File: tb/tb_group_mac_window.sv
// tb_group_mac_window: directed vectors with hand-computed results for group_mac_window.
module tb_group_mac_window;
    logic clk = 1'b0, rst = 1'b0, val = 1'b0, first = 1'b0, last = 1'b0, result_rdy = 1'b1;
    logic [63:0] img = '0, ker = '0, result;
    logic [3:0] result_ovf;
    logic rdy, result_val;
    int n_chk = 0, n_err = 0;
    logic [15:0] q[$];

    group_mac_window dut (
        .clk(clk), .rst(rst), .img(img), .ker(ker), .val(val), .first(first), .last(last),
        .rdy(rdy), .result(result), .result_ovf(result_ovf), .result_val(result_val), .result_rdy(result_rdy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (result_val && result_rdy) q.push_back(result[15:0]);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic send_beat(input logic [63:0] im, input logic [63:0] ke, input logic f, input logic l);
        int n;
        logic ok;
        n = 0;
        img = im; ker = ke; first = f; last = l; val = 1'b1;
        do begin
            @(negedge clk);
            ok = rdy;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        chk("beat_accepted", ok, 1);
        val = 1'b0; first = 1'b0; last = 1'b0;
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!result_val && n < 20);
        chk("result_seen", result_val, 1);
    endtask

    initial begin
        #12 rst = 1'b1;
        #1;
        chk("rst_result", result, 0);
        chk("rst_val", result_val, 0);
        chk("rst_rdy", rdy, 0);
        #9 rst = 1'b0;
        @(posedge clk); #1;
        chk("rdy_after_rst", rdy, 1);

        // 3-beat window on lane0: 3*512 = 1536, >>>8 = 6
        send_beat(p4(256, 0, 0, 0), p4(2, 0, 0, 0), 1, 0);
        send_beat(p4(256, 0, 0, 0), p4(2, 0, 0, 0), 0, 0);
        send_beat(p4(256, 0, 0, 0), p4(2, 0, 0, 0), 0, 1);
        @(negedge clk); chk("lat_e0", result_val, 0);
        @(negedge clk);
        @(negedge clk); chk("lat_e2", result_val, 0);
        @(negedge clk); chk("lat_e3", result_val, 1);
        chk("win3_res", result, p4(6, 0, 0, 0));
        chk("win3_ovf", result_ovf, 0);
        @(posedge clk); #1;

        send_beat(p4(0, -256, -1, 0), p4(0, 256, 1, 0), 1, 1);
        wait_res();
        chk("single_res", result, p4(0, -256, -1, 0));
        chk("single_ovf", result_ovf, 0);
        @(posedge clk); #1;

        send_beat(p4(32767, 0, 0, -32768), p4(32767, 0, 0, 32767), 1, 0);
        send_beat(p4(32767, 0, 0, -32768), p4(32767, 0, 0, 32767), 0, 1);
        wait_res();
        chk("sat_res", result, p4(32767, 0, 0, -32768));
        chk("sat_ovf", result_ovf, 4'b1001);
        @(posedge clk); #1;

        // backpressure: two windows fill the pending count, the third beat must wait
        q.delete();
        result_rdy = 1'b0;
        send_beat(p4(256, 0, 0, 0), p4(1, 0, 0, 0), 1, 1);
        send_beat(p4(512, 0, 0, 0), p4(1, 0, 0, 0), 1, 1);
        @(negedge clk); chk("bp_rdy_low", rdy, 0);
        img = p4(768, 0, 0, 0); ker = p4(1, 0, 0, 0); first = 1'b1; last = 1'b1; val = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_held_rdy", rdy, 0);
        chk("bp_head_val", result_val, 1);
        chk("bp_head", result[15:0], 1);
        @(posedge clk); #1 result_rdy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); chk("bp_rdy_back", rdy, 1);
        @(posedge clk); #1;
        val = 1'b0; first = 1'b0; last = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_count", q.size(), 3);
        for (int i = 0; i < 3; i++) chk("bp_order", (i < q.size()) ? q[i] : 16'hdead, i + 1);

        // reset mid-window discards the partial sum
        send_beat(p4(256, 0, 0, 0), p4(100, 0, 0, 0), 1, 0);
        send_beat(p4(256, 0, 0, 0), p4(100, 0, 0, 0), 0, 0);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("mid_rst_rdy", rdy, 0);
        chk("mid_rst_val", result_val, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rdy_after", rdy, 1);
        send_beat(p4(256, 0, 0, 0), p4(1, 0, 0, 0), 1, 1);
        wait_res();
        chk("fresh_res", result, p4(1, 0, 0, 0));
        chk("fresh_ovf", result_ovf, 0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
